key_event_ctrl: RTL and testbench

- Multi-key debounce controller for the board's push-buttons and switches.
- Replaces one wide timer per key with a single shared prescaler that produces a sample tick, plus a small stable-time counter per key.
- A round-robin arbiter serialises press/release events from all keys into one valid/ready event stream for the downstream game/control FSM.
- Sits between the raw pin inputs and the top-level control logic.

---
 rtl/key_event_ctrl_pkg.sv | 20 ++
 rtl/key_db_channel.sv | 116 +++++++++++
 rtl/key_event_ctrl.sv | 160 ++++++++++++++++
 tb/tb_key_event_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// key_event_ctrl_pkg
// Shared definitions for the multi-key debounce / event controller.
//   key_state_e : per-key debounce FSM state encoding
//   EV_RELEASE  : event type for a 1->0 debounced transition
//   EV_PRESS    : event type for a 0->1 debounced transition
// ---------------------------------------------------------------------------
package key_event_ctrl_pkg;

   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT0 = 2'b01,
      ONE   = 2'b10,
      WAIT1 = 2'b11
   } key_state_e;

   localparam logic EV_RELEASE = 1'b0;
   localparam logic EV_PRESS   = 1'b1;

endpackage : key_event_ctrl_pkg

// File: rtl/key_db_channel.sv
// ---------------------------------------------------------------------------
// key_db_channel
// One debounce channel: 2-flop synchroniser, stable-time FSM and counter.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   sw_i         : raw asynchronous key input
//   tick_i       : shared sample tick (one cycle wide)
//   db_level_o   : registered debounced level
//   ev_o         : one-cycle strobe on the edge the debounced level changes
//   ev_type_o    : EV_PRESS / EV_RELEASE, valid while ev_o is high
// ---------------------------------------------------------------------------
module key_db_channel
   import key_event_ctrl_pkg::*;
#(
   parameter int STABLE_TICKS = 20,
   parameter int CNT_W        = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_i,
   input  logic tick_i,
   output logic db_level_o,
   output logic ev_o,
   output logic ev_type_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic [1:0]       sync_q;
   logic             s;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_level_q, db_level_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], sw_i};
      end
   end

   assign s = sync_q[1];

   // NOTE: every signal driven here gets a default first, so no branch can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ev_o      = 1'b0;
      ev_type_o = EV_RELEASE;
      case (state_q)
         ZERO: begin
            if (s) begin
               state_d = WAIT1;
               cnt_d   = '0;
            end
         end
         WAIT1: begin
            if (!s) begin
               state_d = ZERO;
            end else if (tick_i) begin
               // The tick that completes the stable window accepts the change.
               if (cnt_q == CNT_LAST) begin
                  state_d   = ONE;
                  ev_o      = 1'b1;
                  ev_type_o = EV_PRESS;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ONE: begin
            if (!s) begin
               state_d = WAIT0;
               cnt_d   = '0;
            end
         end
         WAIT0: begin
            if (s) begin
               state_d = ONE;
            end else if (tick_i) begin
               if (cnt_q == CNT_LAST) begin
                  state_d   = ZERO;
                  ev_o      = 1'b1;
                  ev_type_o = EV_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ZERO;
      endcase
   end

   // Level follows the next state so it changes on the same edge the FSM
   // enters ONE or ZERO.
   assign db_level_d = (state_d == ONE) || (state_d == WAIT0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ZERO;
         cnt_q      <= '0;
         db_level_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         db_level_q <= db_level_d;
      end
   end

   assign db_level_o = db_level_q;

endmodule : key_db_channel

// File: rtl/key_event_ctrl.sv
// ---------------------------------------------------------------------------
// key_event_ctrl
// Multi-key debounce controller: shared sample prescaler, one debounce
// channel per key, per-key pending slots and a round-robin arbiter that
// serialises press/release events into one valid/ready stream.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   sw           : raw asynchronous key inputs
//   db_level     : debounced level per key
//   ev_valid     : event available
//   ev_ready     : consumer accepts when ev_valid & ev_ready
//   ev_key       : key index of the current event
//   ev_press     : 1 = press, 0 = release
//   ev_overflow  : one-cycle pulse when a pending event is overwritten
// ---------------------------------------------------------------------------
module key_event_ctrl
   import key_event_ctrl_pkg::*;
#(
   parameter int NUM_KEYS     = 4,
   parameter int IDX_W        = 2,
   parameter int PRESC_DIV    = 50000,
   parameter int STABLE_TICKS = 20,
   parameter int CNT_W        = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] sw,
   output logic [NUM_KEYS-1:0] db_level,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [IDX_W-1:0]    ev_key,
   output logic                ev_press,
   output logic                ev_overflow
);

   localparam int             PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESC_DIV - 1);
   localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(NUM_KEYS - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic                tick;
   logic [NUM_KEYS-1:0] key_ev, key_ev_type;
   logic [NUM_KEYS-1:0] pend_q, pend_d, ptype_q, ptype_d, clr;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic                hi_found, lo_found, found;
   logic [IDX_W-1:0]    hi_win, lo_win, win;
   logic                load;
   logic                ev_valid_q, ev_valid_d, ev_press_q, ev_press_d;
   logic [IDX_W-1:0]    ev_key_q, ev_key_d;
   logic                ev_overflow_q, ev_overflow_d;

   // Shared prescaler: tick is high for the single cycle at the wrap count.
   assign tick    = (presc_q == PRESC_LAST);
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_db_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .CNT_W        (CNT_W)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .sw_i       (sw[i]),
         .tick_i     (tick),
         .db_level_o (db_level[i]),
         .ev_o       (key_ev[i]),
         .ev_type_o  (key_ev_type[i])
      );
   end

   // Round-robin pick: lowest pending index at or above the pointer, else
   // the lowest pending index overall (the wrapped part of the scan).
   always_comb begin
      hi_found = 1'b0;
      hi_win   = '0;
      lo_found = 1'b0;
      lo_win   = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            lo_found = 1'b1;
            lo_win   = IDX_W'(i);
            if (IDX_W'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_win   = IDX_W'(i);
            end
         end
      end
      found = lo_found;
      win   = hi_found ? hi_win : lo_win;
   end

   assign load = !ev_valid_q || ev_ready;

   // Pending slots: a new event always wins over the clear of the same key,
   // and only an overwrite of a slot that stays pending counts as overflow.
   always_comb begin
      pend_d        = pend_q;
      ptype_d       = ptype_q;
      ev_overflow_d = 1'b0;
      clr           = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         clr[i] = load && found && (win == IDX_W'(i));
         if (key_ev[i]) begin
            if (pend_q[i] && !clr[i]) begin
               ev_overflow_d = 1'b1;
            end
            pend_d[i]  = 1'b1;
            ptype_d[i] = key_ev_type[i];
         end else if (clr[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // Output register holds key/type while stalled; loads the winner otherwise.
   always_comb begin
      ev_valid_d = ev_valid_q;
      ev_key_d   = ev_key_q;
      ev_press_d = ev_press_q;
      ptr_d      = ptr_q;
      if (load) begin
         if (found) begin
            ev_valid_d = 1'b1;
            ev_key_d   = win;
            ev_press_d = ptype_q[win];
            ptr_d      = (win == KEY_LAST) ? '0 : win + IDX_W'(1);
         end else begin
            ev_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q       <= '0;
         pend_q        <= '0;
         ptype_q       <= '0;
         ptr_q         <= '0;
         ev_valid_q    <= 1'b0;
         ev_key_q      <= '0;
         ev_press_q    <= 1'b0;
         ev_overflow_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         pend_q        <= pend_d;
         ptype_q       <= ptype_d;
         ptr_q         <= ptr_d;
         ev_valid_q    <= ev_valid_d;
         ev_key_q      <= ev_key_d;
         ev_press_q    <= ev_press_d;
         ev_overflow_q <= ev_overflow_d;
      end
   end

   assign ev_valid    = ev_valid_q;
   assign ev_key      = ev_key_q;
   assign ev_press    = ev_press_q;
   assign ev_overflow = ev_overflow_q;

endmodule : key_event_ctrl

// File: tb/tb_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_event_ctrl
// Self-checking bench for key_event_ctrl with PRESC_DIV=4, STABLE_TICKS=3.
// A reference model tracks, per key, how long the synchronised input has
// disagreed with the debounced level and how many sample ticks have passed
// since; events feed a pending-set / pointer model of the event stream.
// ---------------------------------------------------------------------------
module tb_key_event_ctrl;

   localparam int NK = 4;
   localparam int IW = 2;
   localparam int PD = 4;
   localparam int ST = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] sw;
   logic [NK-1:0] db_level;
   logic          ev_valid;
   logic          ev_ready;
   logic [IW-1:0] ev_key;
   logic          ev_press;
   logic          ev_overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_event_ctrl #(
      .NUM_KEYS     (NK),
      .IDX_W        (IW),
      .PRESC_DIV    (PD),
      .STABLE_TICKS (ST),
      .CNT_W        (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sw          (sw),
      .db_level    (db_level),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_key      (ev_key),
      .ev_press    (ev_press),
      .ev_overflow (ev_overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [NK-1:0] m_s1, m_s2, m_level, m_disagree, m_pend, m_ptype;
   int            m_ticks[NK];
   int            m_presc, m_ptr, m_key;
   logic          m_valid, m_press, m_ovf;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_level = '0; m_disagree = '0;
      m_pend = '0; m_ptype = '0;
      for (int i = 0; i < NK; i++) m_ticks[i] = 0;
      m_presc = 0; m_ptr = 0; m_key = 0;
      m_valid = 1'b0; m_press = 1'b0; m_ovf = 1'b0;
   endtask

   // True when key i's level change will be accepted on the coming edge:
   // the disagreement was already seen on an earlier edge, this edge carries
   // a tick, and it is the STABLE_TICKS-th tick since then.
   function automatic logic m_fires(int i);
      return (m_s2[i] != m_level[i]) && m_disagree[i] &&
             (m_presc == PD - 1) && (m_ticks[i] == ST - 1);
   endfunction

   task automatic model_step();
      logic [NK-1:0] fire, ftype;
      logic          load, found, ovf;
      int            win, j;
      fire = '0; ftype = '0;
      for (int i = 0; i < NK; i++) begin
         if (m_fires(i)) begin
            fire[i]       = 1'b1;
            ftype[i]      = m_s2[i];
            m_level[i]    = m_s2[i];
            m_disagree[i] = 1'b0;
            m_ticks[i]    = 0;
         end else if (m_s2[i] == m_level[i]) begin
            m_disagree[i] = 1'b0;
            m_ticks[i]    = 0;
         end else if (!m_disagree[i]) begin
            m_disagree[i] = 1'b1;
            m_ticks[i]    = 0;
         end else if (m_presc == PD - 1) begin
            m_ticks[i]++;
         end
      end
      load = !m_valid || ev_ready;
      found = 1'b0; win = 0;
      for (int k = 0; k < NK; k++) begin
         j = (m_ptr + k) % NK;
         if (!found && m_pend[j]) begin found = 1'b1; win = j; end
      end
      ovf = 1'b0;
      for (int i = 0; i < NK; i++)
         if (fire[i] && m_pend[i] && !(load && found && win == i)) ovf = 1'b1;
      if (load) begin
         if (found) begin
            m_valid = 1'b1; m_key = win; m_press = m_ptype[win];
            m_pend[win] = 1'b0; m_ptr = (win + 1) % NK;
         end else begin
            m_valid = 1'b0;
         end
      end
      for (int i = 0; i < NK; i++)
         if (fire[i]) begin m_pend[i] = 1'b1; m_ptype[i] = ftype[i]; end
      m_ovf   = ovf;
      m_presc = (m_presc + 1) % PD;
      m_s2    = m_s1;
      m_s1    = sw;
   endtask

   // One clock: advance the model with the pre-edge inputs, compare #1 later.
   task automatic step(input int n = 1);
      logic [31:0] act, exp;
      logic [1:0]  mk;
      repeat (n) begin
         @(posedge clk);
         if (reset) model_reset(); else model_step();
         #1;
         mk  = m_key[1:0];
         exp = {23'd0, m_level, m_valid, m_ovf, m_valid ? mk : 2'b00, m_valid & m_press};
         act = {23'd0, db_level, ev_valid, ev_overflow, m_valid ? ev_key : 2'b00, m_valid & ev_press};
         check("cycle_model", act, exp);
      end
   endtask

   // ---------------- directed + table + random ----------------
   typedef struct {
      int key;
      int pulse;
      int exp_beats;
   } pulse_vec_t;

   pulse_vec_t vecs[5];
   int         beats, lat, ovf_cnt, rk;
   logic [1:0] bk[4];
   logic       bp[4];
   logic       seen;

   task automatic record_beat();
      if (ev_valid && ev_ready) begin
         if (beats < 4) begin bk[beats] = ev_key; bp[beats] = ev_press; end
         beats++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; sw = '0; ev_ready = 1'b0;
      model_reset();
      #2;
      check("reset_outputs", {23'd0, db_level, ev_valid, ev_overflow, ev_key, ev_press}, 32'd0);
      step(2);
      reset = 1'b0;
      step(3);

      // T1: key0 press then release.
      ev_ready = 1'b1; sw[0] = 1'b1;
      seen = 1'b0; lat = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         step(1);
         if (db_level[0]) begin seen = 1'b1; lat = c; end
      end
      check("t1_level_rise_seen", {31'd0, seen}, 32'd1);
      check("t1_latency_in_window", {31'd0, (lat >= 12 && lat <= 15)}, 32'd1);
      check("t1_no_valid_with_level", {31'd0, ev_valid}, 32'd0);
      step(1);
      check("t1_press_beat", {29'd0, ev_valid, ev_key, ev_press}, {29'd0, 1'b1, 2'd0, 1'b1});
      step(1);
      check("t1_single_beat", {31'd0, ev_valid}, 32'd0);
      sw[0] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 25 && !seen; c++) begin
         step(1);
         if (ev_valid) seen = 1'b1;
      end
      check("t1_release_beat", {29'd0, ev_valid, ev_key, ev_press}, {29'd0, 1'b1, 2'd0, 1'b0});
      step(3);

      // Table: pulses of various widths; short ones must be filtered out.
      vecs[0] = '{key: 1, pulse: 5,  exp_beats: 0};
      vecs[1] = '{key: 2, pulse: 8,  exp_beats: 0};
      vecs[2] = '{key: 0, pulse: 9,  exp_beats: 0};
      vecs[3] = '{key: 2, pulse: 16, exp_beats: 2};
      vecs[4] = '{key: 3, pulse: 24, exp_beats: 2};
      for (int v = 0; v < 5; v++) begin
         beats = 0;
         sw[vecs[v].key] = 1'b1;
         for (int c = 0; c < vecs[v].pulse; c++) begin record_beat(); step(1); end
         sw[vecs[v].key] = 1'b0;
         for (int c = 0; c < 40; c++) begin record_beat(); step(1); end
         check($sformatf("vec%0d_beats", v), beats, vecs[v].exp_beats);
         check($sformatf("vec%0d_level", v), {28'd0, db_level}, 32'd0);
         if (vecs[v].exp_beats == 2) begin
            check($sformatf("vec%0d_first", v), {29'd0, bk[0], bp[0]}, {29'd0, 2'(vecs[v].key), 1'b1});
            check($sformatf("vec%0d_second", v), {29'd0, bk[1], bp[1]}, {29'd0, 2'(vecs[v].key), 1'b0});
         end
      end

      // T3: simultaneous keys 1 and 3, press then release.
      for (int ph = 0; ph < 2; ph++) begin
         sw[1] = (ph == 0); sw[3] = (ph == 0);
         seen = 1'b0;
         for (int c = 0; c < 25 && !seen; c++) begin
            step(1);
            if (ev_valid) seen = 1'b1;
         end
         check($sformatf("t3_ph%0d_first", ph), {29'd0, ev_valid, ev_key, ev_press},
               {29'd0, 1'b1, 2'd1, ph == 0});
         step(1);
         check($sformatf("t3_ph%0d_second", ph), {29'd0, ev_valid, ev_key, ev_press},
               {29'd0, 1'b1, 2'd3, ph == 0});
         step(1);
         check($sformatf("t3_ph%0d_idle", ph), {31'd0, ev_valid}, 32'd0);
      end
      step(3);

      // T4: stalled consumer, overwrite of key0's pending press.
      ev_ready = 1'b0; sw[2] = 1'b1; ovf_cnt = 0;
      seen = 1'b0;
      for (int c = 0; c < 25 && !seen; c++) begin
         step(1);
         if (ev_valid) seen = 1'b1;
      end
      check("t4_key2_valid", {29'd0, ev_valid, ev_key, ev_press}, {29'd0, 1'b1, 2'd2, 1'b1});
      sw[0] = 1'b1;
      for (int c = 0; c < 25 && !db_level[0]; c++) begin
         step(1);
         if (ev_overflow) ovf_cnt++;
      end
      sw[0] = 1'b0;
      for (int c = 0; c < 25; c++) begin
         step(1);
         if (ev_overflow) ovf_cnt++;
      end
      check("t4_overflow_once", ovf_cnt, 1);
      check("t4_hold_key2", {29'd0, ev_valid, ev_key, ev_press}, {29'd0, 1'b1, 2'd2, 1'b1});
      ev_ready = 1'b1; beats = 0;
      for (int c = 0; c < 10; c++) begin record_beat(); step(1); end
      check("t4_two_beats", beats, 2);
      check("t4_beat0", {29'd0, bk[0], bp[0]}, {29'd0, 2'd2, 1'b1});
      check("t4_beat1", {29'd0, bk[1], bp[1]}, {29'd0, 2'd0, 1'b0});
      sw[2] = 1'b0;
      step(30);

      // T5: reset while key3 is part-way through its stable window.
      sw[3] = 1'b1;
      step(6);
      check("t5_not_yet_accepted", {31'd0, db_level[3]}, 32'd0);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check("t5_async_reset", {23'd0, db_level, ev_valid, ev_overflow, ev_key, ev_press}, 32'd0);
      step(2);
      reset = 1'b0;
      seen = 1'b0; lat = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         step(1);
         if (ev_valid && !db_level[3]) check("t5_no_early_event", 32'd1, 32'd0);
         if (db_level[3]) begin seen = 1'b1; lat = c; end
      end
      check("t5_full_debounce", lat, 12);
      step(1);
      check("t5_press_key3", {29'd0, ev_valid, ev_key, ev_press}, {29'd0, 1'b1, 2'd3, 1'b1});
      sw[3] = 1'b0;
      step(30);

      // T6: key0 release fires on the edge its pending press is taken.
      ev_ready = 1'b0; sw[2] = 1'b1;
      for (int c = 0; c < 25 && !ev_valid; c++) step(1);
      sw[0] = 1'b1;
      for (int c = 0; c < 25 && !db_level[0]; c++) step(1);
      sw[0] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         if (m_fires(0)) seen = 1'b1; else step(1);
      end
      check("t6_release_predicted", {31'd0, seen}, 32'd1);
      ev_ready = 1'b1;
      step(1);
      check("t6_press_taken", {29'd0, ev_valid, ev_key, ev_press}, {29'd0, 1'b1, 2'd0, 1'b1});
      check("t6_no_overflow", {31'd0, ev_overflow}, 32'd0);
      step(1);
      check("t6_release_kept", {29'd0, ev_valid, ev_key, ev_press}, {29'd0, 1'b1, 2'd0, 1'b0});
      check("t6_still_no_overflow", {31'd0, ev_overflow}, 32'd0);
      sw[2] = 1'b0;
      step(30);

      // Random: key toggles, consumer back-pressure, rare resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            rk = int'($urandom_range(0, NK - 1));
            sw[rk] = ~sw[rk];
         end
         ev_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b1;
            step(2);
            reset = 1'b0;
         end
         step(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_key_event_ctrl
